// File: rtl/alu_exec.sv
// Registered, handshaked ALU execute stage with zero/overflow/invalid flags.
// Optional iterative multiplier (code 3) is built only when ALU_MULT_EN is defined.
//
// Ports:
//   clock, reset          rising-edge clock, async active-high reset
//   in_valid / in_ready   request handshake (in_ready is combinational)
//   ALUcontrole, A, B     op code and operands, sampled on accept
//   out_valid / out_ready result handshake
//   resultado             registered result
//   zero, overflow,       registered flags
//   invalido
module alu_exec #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALUcontrole,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] resultado,
  output logic             zero,
  output logic             overflow,
  output logic             invalido
);

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;
  localparam logic [3:0] OP_NOR = 4'd12;

`ifdef ALU_MULT_EN
  localparam logic [3:0] OP_MUL = 4'd3;
  localparam int         CW     = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    HOLD = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd2
  } state_t;
`endif

  state_t state_q, state_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             inv_q, inv_d;

  logic accept;
  logic is_mul;
  logic load_alu;
  logic mul_done;

  // ---------------------------------------------------------------
  // Combinational ALU
  // ---------------------------------------------------------------
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             a_msb;
  logic             b_msb;
  logic             slt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic             alu_inv;

  logic op_and, op_or, op_add;
  logic op_sub, op_slt, op_nor;

  assign sum   = A + B;
  assign diff  = A - B;
  assign a_msb = A[WIDTH-1];
  assign b_msb = B[WIDTH-1];

  // Differing signs decide directly; otherwise A-B cannot
  // overflow and its sign bit is the answer.
  assign slt = (a_msb ^ b_msb) ? a_msb : diff[WIDTH-1];

  assign op_and = (ALUcontrole == OP_AND);
  assign op_or  = (ALUcontrole == OP_OR);
  assign op_add = (ALUcontrole == OP_ADD);
  assign op_sub = (ALUcontrole == OP_SUB);
  assign op_slt = (ALUcontrole == OP_SLT);
  assign op_nor = (ALUcontrole == OP_NOR);

  always_comb begin
    alu_res = sum;
    alu_ovf = 1'b0;
    alu_inv = 1'b0;
    unique case (1'b1)
      op_and: alu_res = A & B;
      op_or:  alu_res = A | B;
      op_add: begin
        alu_res = sum;
        alu_ovf = (a_msb == b_msb) &&
                  (sum[WIDTH-1] != a_msb);
      end
      op_sub: begin
        alu_res = diff;
        alu_ovf = (a_msb != b_msb) &&
                  (diff[WIDTH-1] != a_msb);
      end
      op_slt: alu_res = {{(WIDTH-1){1'b0}}, slt};
      op_nor: alu_res = ~(A | B);
      default: begin
        alu_res = sum;
        alu_inv = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------
  always_comb begin
    in_ready = 1'b0;
    unique case (state_q)
      IDLE:    in_ready = 1'b1;
      HOLD:    in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  assign accept = in_valid && in_ready;

  // ---------------------------------------------------------------
  // Iterative shift-add multiplier
  // ---------------------------------------------------------------
`ifdef ALU_MULT_EN
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mul_busy;

  assign is_mul   = (ALUcontrole == OP_MUL);
  assign mul_busy = (state_q == MULT) &&
                    (cnt_q != CW'(WIDTH));
  // One extra cycle after the last bit to
  // write the product into the result regs.
  assign mul_done = (state_q == MULT) &&
                    (cnt_q == CW'(WIDTH));

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (accept && is_mul) begin
      mcand_d  = A;
      mplier_d = B;
      acc_d    = '0;
      cnt_d    = '0;
    end else if (mul_busy) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end
`else
  assign is_mul   = 1'b0;
  assign mul_done = 1'b0;
`endif

  assign load_alu = accept && !is_mul;

  // ---------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
`ifdef ALU_MULT_EN
          state_d = is_mul ? MULT : HOLD;
`else
          state_d = HOLD;
`endif
        end
      end
      HOLD: begin
        if (out_ready) begin
          if (accept) begin
`ifdef ALU_MULT_EN
            state_d = is_mul ? MULT : HOLD;
`else
            state_d = HOLD;
`endif
          end else begin
            state_d = IDLE;
          end
        end
      end
`ifdef ALU_MULT_EN
      MULT: begin
        if (mul_done) begin
          state_d = HOLD;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------
  // FSM: outputs / result register next values
  // ---------------------------------------------------------------
  always_comb begin
    res_d       = res_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    inv_d       = inv_q;
    out_valid_d = (state_d == HOLD);
    if (load_alu) begin
      res_d  = alu_res;
      zero_d = (alu_res == '0);
      ovf_d  = alu_ovf;
      inv_d  = alu_inv;
    end
`ifdef ALU_MULT_EN
    else if (mul_done) begin
      res_d  = acc_q;
      zero_d = (acc_q == '0);
      ovf_d  = 1'b0;
      inv_d  = 1'b0;
    end
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      res_q       <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      inv_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      inv_q       <= inv_d;
    end
  end

  assign out_valid = out_valid_q;
  assign resultado = res_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;
  assign invalido  = inv_q;

endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: directed vectors push expectations,
// a negedge monitor pops and compares on every output handshake.
module tb_alu_exec;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] res;
    logic         z;
    logic         ov;
    logic         inv;
  } exp_t;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   ALUcontrole = '0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] resultado;
  logic         zero;
  logic         overflow;
  logic         invalido;

  int n_tests = 0;
  int n_fail  = 0;
  exp_t exp_q[$];

  alu_exec #(.WIDTH(W)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .ALUcontrole (ALUcontrole),
    .A           (A),
    .B           (B),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .resultado   (resultado),
    .zero        (zero),
    .overflow    (overflow),
    .invalido    (invalido)
  );

  always #5 clock = ~clock;

  function automatic exp_t mk(input logic [W-1:0] r,
                              input logic z,
                              input logic ov,
                              input logic inv);
    exp_t e;
    e.res = r;
    e.z   = z;
    e.ov  = ov;
    e.inv = inv;
    return e;
  endfunction

  task automatic chk(input string name,
                     input logic [W-1:0] act,
                     input logic [W-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: one pop per output handshake.
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got res=%h with empty queue",
                 resultado);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (resultado !== e.res || zero !== e.z ||
            overflow !== e.ov || invalido !== e.inv) begin
          n_fail++;
          $display("FAIL sb_result: got res=%h z=%b ov=%b inv=%b expected res=%h z=%b ov=%b inv=%b",
                   resultado, zero, overflow, invalido,
                   e.res, e.z, e.ov, e.inv);
        end
      end
    end
  end

  // Present a request, wait (bounded) for acceptance, push expectation.
  task automatic issue(input logic [3:0] c,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b,
                       input exp_t e,
                       input bit single);
    int n;
    n = 0;
    in_valid    = 1'b1;
    ALUcontrole = c;
    A           = a;
    B           = b;
    while (!in_ready && n < 60) begin
      @(posedge clock); #1;
      n++;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready=%b expected 1", in_ready);
    end else begin
      exp_q.push_back(e);
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
    if (single) chk("latency1_out_valid", W'(out_valid), W'(1));
  endtask

  initial begin
    int n;
    // Reset state
    #1;
    chk("rst_out_valid", W'(out_valid), '0);
    chk("rst_resultado", resultado, '0);
    chk("rst_flags", W'({zero, overflow, invalido}), '0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    chk("idle_in_ready", W'(in_ready), W'(1));

    // Arithmetic and flags
    issue(4'd2, 32'h7FFF_FFFF, 32'd1,
          mk(32'h8000_0000, 0, 1, 0), 1);
    issue(4'd6, 32'd5, 32'd5, mk(32'd0, 1, 0, 0), 1);
    issue(4'd7, 32'h8000_0000, 32'd1, mk(32'd1, 0, 0, 0), 1);
    issue(4'd7, 32'h7FFF_FFFF, 32'h8000_0000,
          mk(32'd0, 1, 0, 0), 1);
    issue(4'd7, 32'd5, 32'hFFFF_FFFD, mk(32'd0, 1, 0, 0), 1);
    issue(4'd7, 32'hFFFF_FFFF, 32'd0, mk(32'd1, 0, 0, 0), 1);
    issue(4'd6, 32'h8000_0000, 32'd1,
          mk(32'h7FFF_FFFF, 0, 1, 0), 1);
    issue(4'd2, 32'hFFFF_FFFF, 32'd1, mk(32'd0, 1, 0, 0), 1);
    issue(4'd1, 32'h0F00_00F0, 32'h00F0_0F00,
          mk(32'h0FF0_0FF0, 0, 0, 0), 1);
    issue(4'd9, 32'd2, 32'd3, mk(32'd5, 0, 0, 1), 1);
    issue(4'd15, 32'h8000_0000, 32'h8000_0000,
          mk(32'd0, 1, 0, 1), 1);
`ifndef ALU_MULT_EN
    issue(4'd3, 32'd2, 32'd3, mk(32'd5, 0, 0, 1), 1);
`endif

    // Drain to IDLE
    @(posedge clock); #1;
    chk("drain_out_valid", W'(out_valid), '0);

    // Back-to-back with stall
    out_ready = 1'b0;
    issue(4'd0, 32'h0000_F0F0, 32'h0000_FF00,
          mk(32'h0000_F000, 0, 0, 0), 1);
    in_valid    = 1'b1;
    ALUcontrole = 4'd12;
    A           = '0;
    B           = '0;
    for (int k = 0; k < 3; k++) begin
      chk("stall_resultado", resultado, 32'h0000_F000);
      chk("stall_in_ready", W'(in_ready), '0);
      chk("stall_out_valid", W'(out_valid), W'(1));
      @(posedge clock); #1;
    end
    out_ready = 1'b1;
    exp_q.push_back(mk(32'hFFFF_FFFF, 0, 0, 0));
    #1;
    chk("unstall_in_ready", W'(in_ready), W'(1));
    @(posedge clock); #1;
    in_valid = 1'b0;
    chk("b2b_out_valid", W'(out_valid), W'(1));
    chk("b2b_resultado", resultado, 32'hFFFF_FFFF);
    @(posedge clock); #1;

`ifdef ALU_MULT_EN
    issue(4'd3, 32'd7, 32'd6, mk(32'd42, 0, 0, 0), 0);
    for (int k = 0; k <= W; k++) begin
      chk("mul_busy_out_valid", W'(out_valid), '0);
      chk("mul_busy_in_ready", W'(in_ready), '0);
      @(posedge clock); #1;
    end
    chk("mul_done_out_valid", W'(out_valid), W'(1));
    chk("mul_resultado", resultado, 32'd42);
    @(posedge clock); #1;
    out_ready = 1'b0;
    issue(4'd3, 32'd9, 32'd9, mk(32'd81, 0, 0, 0), 0);
    repeat (9) begin
      @(posedge clock); #1;
    end
`else
    out_ready = 1'b0;
    issue(4'd2, 32'd10, 32'd20, mk(32'd30, 0, 0, 0), 1);
`endif

    // Async reset mid-operation
    #2;
    reset = 1'b1;
    #1;
    chk("async_out_valid", W'(out_valid), '0);
    chk("async_resultado", resultado, '0);
    exp_q.delete();
    @(posedge clock); #1;
    reset     = 1'b0;
    out_ready = 1'b1;
    @(posedge clock); #1;
    chk("post_rst_in_ready", W'(in_ready), W'(1));
    issue(4'd2, 32'd1, 32'd1, mk(32'd2, 0, 0, 0), 1);
    chk("post_rst_resultado", resultado, 32'd2);

    // Wait for scoreboard to drain
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    chk("sb_drained", W'(exp_q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
